// File: rtl/acc_pkg.sv
// Shared definitions for the multi-channel accumulator: mode encodings and a
// helper that sizes channel-select fields so a single channel still gets one bit.
package acc_pkg;

    localparam logic [1:0] MODE_WRAP_ADD = 2'b00;
    localparam logic [1:0] MODE_SAT_ADD  = 2'b01;
    localparam logic [1:0] MODE_WRAP_SUB = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/acc_lane.sv
// One accumulator channel: increment register, running accumulator, sticky
// overflow flag and a one-cycle carry/borrow tick.
module acc_lane
    import acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int IN_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             inc_we,
    input  logic [IN_W-1:0]  inc_data,
    input  logic             ovf_clr,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             tick
);

    logic [IN_W-1:0]  inc_q;
    logic [ACC_W-1:0] inc_ext;
    logic [ACC_W:0]   sum;
    logic [ACC_W:0]   diff;
    logic [ACC_W-1:0] acc_d;
    logic             carry;
    logic             wrap;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        inc_ext = ACC_W'(inc_q);
        sum     = {1'b0, acc} + {1'b0, inc_ext};
        diff    = {1'b0, acc} - {1'b0, inc_ext};
        acc_d   = acc;
        carry   = 1'b0;
        wrap    = 1'b0;
        if (en && !clr) begin
            case (mode)
                MODE_WRAP_ADD: begin
                    acc_d = sum[ACC_W-1:0];
                    carry = sum[ACC_W];
                    wrap  = sum[ACC_W];
                end
                MODE_SAT_ADD: begin
                    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    carry = sum[ACC_W];
                end
                MODE_WRAP_SUB: begin
                    acc_d = diff[ACC_W-1:0];
                    carry = diff[ACC_W];
                    wrap  = diff[ACC_W];
                end
                default: ;
            endcase
        end
    end

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            inc_q <= '0;
            ovf   <= 1'b0;
            tick  <= 1'b0;
        end else begin
            acc  <= clr ? '0 : acc_d;
            tick <= wrap;
            // A fresh overflow beats a simultaneous clear request.
            ovf  <= carry | (ovf & ~ovf_clr);
            if (inc_we) begin
                inc_q <= inc_data;
            end
        end
    end

endmodule

// File: rtl/multi_channel_accumulator.sv
// N-channel accumulator / phase accumulator: increment write decode, one lane
// per channel, and a registered read-back of the selected channel's MSB slice.
module multi_channel_accumulator
    import acc_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int IN_W  = 8,
    parameter int OUT_W = 8,
    parameter int N_CH  = 2,
    localparam int CH_W = sel_w(N_CH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             clr,
    input  logic             inc_wr,
    input  logic [CH_W-1:0]  inc_ch,
    input  logic [IN_W-1:0]  inc_data,
    input  logic [CH_W-1:0]  rd_ch,
    input  logic             ovf_clr,
    output logic [OUT_W-1:0] out_msb,
    output logic [N_CH-1:0]  ovf,
    output logic [N_CH-1:0]  tick
);

    logic [ACC_W-1:0] acc_all [N_CH];
    logic [ACC_W-1:0] rd_val;

    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        acc_lane #(
            .ACC_W (ACC_W),
            .IN_W  (IN_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .mode     (mode),
            .clr      (clr),
            .inc_we   (inc_wr && (inc_ch == CH_W'(g))),
            .inc_data (inc_data),
            .ovf_clr  (ovf_clr),
            .acc      (acc_all[g]),
            .ovf      (ovf[g]),
            .tick     (tick[g])
        );
    end

    // Unmapped channel numbers read back as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_val = acc_all[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_msb <= '0;
        end else begin
            out_msb <= rd_val[ACC_W-1 -: OUT_W];
        end
    end

endmodule
